// File: rtl/riscv_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory port, execute-stage redirect and
// the decode-side instruction handoff. 'master' is the fetch unit, 'slave'
// is its environment (memory + pipeline).
interface riscv_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_fault;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_fault,
    input  imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_fault,
    output imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/riscv_fetch.sv
// riscv_fetch: single-outstanding instruction fetch unit with a DEPTH-entry
// {pc,instr} buffer toward decode and redirect/flush handling.
// Optional macro FETCH_MISALIGN_CHECK_EN: misaligned redirect targets raise a
// sticky if_fault that blocks fetching; otherwise the target's low bits are
// cleared.
module riscv_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input logic           clk,
  input logic           rst,
  riscv_fetch_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, WAIT_DROP} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ibuf_ent_t;

  state_t      state, state_nx;
  logic [31:0] fetch_pc, req_pc;
  ibuf_ent_t   ibuf [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic        req, push, pop, accept, fault;
  logic [31:0] redir_tgt;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redir_tgt = bus.redirect_pc;

  // Sticky fault: set by a misaligned redirect, cleared by an aligned one.
  always_ff @(posedge clk) begin
    if (rst)                     fault <= 1'b0;
    else if (bus.redirect_valid) fault <= |bus.redirect_pc[1:0];
  end
`else
  logic unused_redir_lo;
  assign unused_redir_lo = ^bus.redirect_pc[1:0];
  assign redir_tgt = {bus.redirect_pc[31:2], 2'b00};
  assign fault     = 1'b0;
`endif

  // Memory handshake and decode handoff; everything is quiet during reset.
  assign bus.imem_req  = req & ~rst;
  assign bus.imem_addr = fetch_pc;
  assign accept        = bus.imem_req & bus.imem_ready;
  assign bus.if_valid  = (count != '0) & ~rst;
  assign bus.if_instr  = ibuf[rd_ptr].instr;
  assign bus.if_pc     = ibuf[rd_ptr].pc;
  assign bus.if_fault  = fault;
  // A redirect flushes the buffer, so it also cancels the same-cycle pop.
  assign pop           = bus.if_valid & bus.if_ready & ~bus.redirect_valid;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // FSM next state, request enable and buffer push.
  always_comb begin
    state_nx = state;
    req      = 1'b0;
    push     = 1'b0;
    case (state)
      IDLE: begin
        req = (count < FULL) & ~bus.redirect_valid & ~fault;
        if (req && bus.imem_ready) state_nx = WAIT;
      end
      WAIT: begin
        // A response arriving with the redirect is consumed and dropped, so
        // there is nothing left to wait for; otherwise drop the late one.
        if (bus.redirect_valid)   state_nx = bus.imem_rvalid ? IDLE : WAIT_DROP;
        else if (bus.imem_rvalid) begin
          push     = 1'b1;
          state_nx = IDLE;
        end
      end
      WAIT_DROP: begin
        if (bus.imem_rvalid) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Fetch pc, buffer pointers and occupancy; redirect overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= redir_tgt;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (accept) begin
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Buffer storage write.
  always_ff @(posedge clk) begin
    if (push && !rst) ibuf[wr_ptr] <= '{pc: req_pc, instr: bus.imem_rdata};
  end
endmodule

// File: tb/tb_riscv_fetch.sv
// Bench for riscv_fetch: a directed cycle table for the corner cases, then
// randomized memory/decode/redirect traffic against a queue-based model.
module tb_riscv_fetch;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  riscv_fetch_if bus();
  riscv_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  typedef struct {
    logic rst, rdy, rvin;
    logic [31:0] rva;
    logic ifr, rdr;
    logic [31:0] rpc;
    logic e_req;
    logic [31:0] e_addr;
    logic e_v;
    logic [31:0] e_pc;
    logic e_flt;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, rdy, rvin, input logic [31:0] rva,
                     input logic ifr, rdr, input logic [31:0] rpc,
                     input logic e_req, input logic [31:0] e_addr,
                     input logic e_v, input logic [31:0] e_pc, input logic e_flt);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.rvin = rvin; v.rva = rva; v.ifr = ifr; v.rdr = rdr;
    v.rpc = rpc; v.e_req = e_req; v.e_addr = e_addr; v.e_v = e_v; v.e_pc = e_pc;
    v.e_flt = e_flt;
    tbl.push_back(v);
  endtask

  // Random-phase reference model state.
  logic [31:0] m_fetch, m_addr, tgt;
  logic        m_busy, m_live, m_fault, e_req, do_pop;
  int          m_cnt;
  logic [31:0] fq[$];

  initial begin
    bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.if_ready = 1'b0;

    //   rst rdy rv rva            ifr rdr rpc           | req addr          v pc            flt
    add(1, 1, 0, 0,             0, 0, 0,             0, 0,             0, 0,             0); // 0 reset
    add(1, 1, 0, 0,             0, 0, 0,             0, 0,             0, 0,             0);
    add(0, 1, 0, 0,             0, 0, 0,             1, 32'h0,         0, 0,             0); // 2 first req
    add(0, 1, 1, 32'h0,         0, 0, 0,             0, 0,             0, 0,             0);
    add(0, 1, 0, 0,             0, 0, 0,             1, 32'h4,         1, 32'h0,         0);
    add(0, 1, 1, 32'h4,         0, 0, 0,             0, 0,             1, 32'h0,         0);
    add(0, 1, 0, 0,             0, 0, 0,             0, 0,             1, 32'h0,         0); // 6 full
    add(0, 1, 0, 0,             0, 0, 0,             0, 0,             1, 32'h0,         0);
    add(0, 1, 0, 0,             1, 0, 0,             0, 0,             1, 32'h0,         0); // 8 drain
    add(0, 1, 0, 0,             1, 0, 0,             1, 32'h8,         1, 32'h4,         0);
    add(0, 1, 0, 0,             1, 0, 0,             0, 0,             0, 0,             0);
    add(0, 1, 0, 0,             1, 1, 32'h100,       0, 0,             0, 0,             0); // 11 redirect in WAIT
    add(0, 1, 1, 32'h8,         1, 0, 0,             0, 0,             0, 0,             0); // dropped
    add(0, 1, 0, 0,             1, 0, 0,             1, 32'h100,       0, 0,             0);
    add(0, 1, 1, 32'h100,       1, 0, 0,             0, 0,             0, 0,             0);
    add(0, 1, 0, 0,             0, 0, 0,             1, 32'h104,       1, 32'h100,       0);
    add(0, 1, 1, 32'h104,       1, 1, 32'h200,       0, 0,             1, 32'h100,       0); // 16 redir+rvalid+pop
    add(0, 1, 0, 0,             1, 0, 0,             1, 32'h200,       0, 0,             0);
    add(0, 1, 1, 32'h200,       1, 0, 0,             0, 0,             0, 0,             0);
    add(0, 1, 0, 0,             1, 0, 0,             1, 32'h204,       1, 32'h200,       0);
    add(0, 1, 0, 0,             1, 1, 32'hFFFF_FFFC, 0, 0,             0, 0,             0); // 20 wrap target
    add(0, 1, 1, 32'h204,       1, 0, 0,             0, 0,             0, 0,             0);
    add(0, 0, 0, 0,             1, 0, 0,             1, 32'hFFFF_FFFC, 0, 0,             0); // held
    add(0, 1, 0, 0,             1, 0, 0,             1, 32'hFFFF_FFFC, 0, 0,             0);
    add(0, 1, 1, 32'hFFFF_FFFC, 0, 0, 0,             0, 0,             0, 0,             0);
    add(0, 1, 0, 0,             0, 0, 0,             1, 32'h0,         1, 32'hFFFF_FFFC, 0); // 25 wrapped
    add(0, 1, 0, 0,             0, 1, 32'h102,       0, 0,             1, 32'hFFFF_FFFC, 0); // 26 misaligned
    add(0, 1, 1, 32'h0,         0, 0, 0,             0, 0,             0, 0,             MIS);
    add(0, 0, 0, 0,             0, 0, 0,             !MIS, 32'h100,    0, 0,             MIS);
    add(0, 0, 0, 0,             0, 1, 32'h200,       0, 0,             0, 0,             MIS);
    add(0, 1, 0, 0,             0, 0, 0,             1, 32'h200,       0, 0,             0); // 30
    add(0, 1, 1, 32'h200,       0, 0, 0,             0, 0,             0, 0,             0);
    add(0, 1, 0, 0,             1, 0, 0,             1, 32'h204,       1, 32'h200,       0);
    add(1, 1, 0, 0,             1, 0, 0,             0, 0,             0, 0,             0); // 33 rst mid-txn
    add(0, 0, 1, 32'h204,       1, 0, 0,             1, 32'h0,         0, 0,             0); // stale rvalid
    add(0, 1, 0, 0,             1, 0, 0,             1, 32'h0,         0, 0,             0);
    add(0, 1, 1, 32'h0,         1, 0, 0,             0, 0,             0, 0,             0);
    add(0, 0, 0, 0,             1, 0, 0,             1, 32'h4,         1, 32'h0,         0);

    foreach (tbl[i]) begin
      rst                = tbl[i].rst;
      bus.imem_ready     = tbl[i].rdy;
      bus.imem_rvalid    = tbl[i].rvin;
      bus.imem_rdata     = tbl[i].rvin ? instr_of(tbl[i].rva) : 32'hDEAD_BEEF;
      bus.if_ready       = tbl[i].ifr;
      bus.redirect_valid = tbl[i].rdr;
      bus.redirect_pc    = tbl[i].rpc;
      @(negedge clk);
      chk($sformatf("row%0d imem_req", i), 32'(bus.imem_req), 32'(tbl[i].e_req));
      if (tbl[i].e_req)
        chk($sformatf("row%0d imem_addr", i), bus.imem_addr, tbl[i].e_addr);
      chk($sformatf("row%0d if_valid", i), 32'(bus.if_valid), 32'(tbl[i].e_v));
      if (tbl[i].e_v) begin
        chk($sformatf("row%0d if_pc", i), bus.if_pc, tbl[i].e_pc);
        chk($sformatf("row%0d if_instr", i), bus.if_instr, instr_of(tbl[i].e_pc));
      end
      chk($sformatf("row%0d if_fault", i), 32'(bus.if_fault), 32'(tbl[i].e_flt));
      @(posedge clk); #1;
    end

    // Randomized phase: reset, then a memory with 1..3 cycle latency,
    // random stalls, random decode backpressure and occasional redirects.
    rst = 1'b1; bus.imem_rvalid = 1'b0; bus.redirect_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    m_fetch = 32'h0; m_busy = 1'b0; m_live = 1'b0; m_fault = 1'b0; m_cnt = 0;
    m_addr = '0; fq.delete();

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (m_busy) m_cnt--;
      bus.imem_rvalid = m_busy && (m_cnt == 0);
      bus.imem_rdata  = bus.imem_rvalid ? instr_of(m_addr) : $urandom;
      bus.imem_ready  = ($urandom_range(0, 3) != 0);
      bus.if_ready    = ($urandom_range(0, 2) != 0);
      bus.redirect_valid = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 7))
        0:       tgt = 32'hFFFF_FFFC;
        1:       tgt = 32'hFFFF_FFF8;
        default: tgt = $urandom & 32'h0000_0FFC;
      endcase
      if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      bus.redirect_pc = tgt;
      @(negedge clk);

      e_req = !m_busy && (fq.size() < DEPTH) && !bus.redirect_valid && !m_fault;
      chk($sformatf("rnd%0d imem_req", cyc), 32'(bus.imem_req), 32'(e_req));
      if (e_req) chk($sformatf("rnd%0d imem_addr", cyc), bus.imem_addr, m_fetch);
      chk($sformatf("rnd%0d if_valid", cyc), 32'(bus.if_valid), 32'(fq.size() != 0));
      if (fq.size() != 0) begin
        chk($sformatf("rnd%0d if_pc", cyc), bus.if_pc, fq[0]);
        chk($sformatf("rnd%0d if_instr", cyc), bus.if_instr, instr_of(fq[0]));
      end
      chk($sformatf("rnd%0d if_fault", cyc), 32'(bus.if_fault), 32'(m_fault));

      // Model the effect of the coming clock edge.
      if (bus.redirect_valid) begin
        fq.delete();
        m_fault = MIS && (bus.redirect_pc[1:0] != 2'b00);
        m_fetch = MIS ? bus.redirect_pc : {bus.redirect_pc[31:2], 2'b00};
        m_live  = 1'b0;
        if (bus.imem_rvalid) m_busy = 1'b0;
      end else begin
        do_pop = (fq.size() != 0) && bus.if_ready;
        if (do_pop) void'(fq.pop_front());
        if (bus.imem_rvalid) begin
          if (m_live) fq.push_back(m_addr);
          m_busy = 1'b0;
        end
        if (e_req && bus.imem_ready) begin
          m_busy  = 1'b1;
          m_live  = 1'b1;
          m_addr  = m_fetch;
          m_cnt   = $urandom_range(1, 3);
          m_fetch = m_fetch + 32'd4;
        end
      end
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
